// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stage_sequencer
//  Description : N-stage start/done sequencer. Launches datapath loops in
//                strict order with a start/done handshake, per-stage
//                watchdog, abort, clear/restart, start-hold mode and an
//                error-stage report. Drives {error, done, busy} status LEDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter bit HOLD_STARTS    = 1'b1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int IDX_W          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clok,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  abort,
  input  logic                  clear,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      error_stage,
  output logic [2:0]            light
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0]      LAST_STAGE  = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE_HOT0    = NUM_STAGES'(1);
  localparam logic [23:0]           TIMER_MAX   = 24'hFF_FFFF;
  // Only meaningful when the watchdog is enabled.
  localparam logic [23:0]           TIMER_LIMIT = 24'(TIMEOUT_CYCLES - 1);
  localparam bit                    TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_t                  state;
  logic [23:0]             timer;
  logic [IDX_W-1:0]        next_stage;
  logic                    cur_done;
  logic [NUM_STAGES-1:0]   next_start;

  // Done of the stage being waited on, and the start pattern for its successor.
  always_comb begin
    next_stage = cur_stage + IDX_W'(1);
    cur_done   = stage_done[cur_stage];
    next_start = (HOLD_STARTS ? stage_start : '0) | (ONE_HOT0 << next_stage);
  end

  // Sequencer state machine with all outputs registered alongside the state.
  always_ff @(posedge clok or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      stage_start <= '0;
      cur_stage   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_stage <= '0;
      light       <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (go) begin
            state       <= S_WAIT;
            cur_stage   <= '0;
            stage_start <= ONE_HOT0;
            timer       <= '0;
            busy        <= 1'b1;
            light       <= 3'b001;
          end
        end

        S_WAIT: begin
          if (abort) begin
            // Abort is a clean cancel, not a fault: no error flag.
            state       <= S_IDLE;
            stage_start <= '0;
            cur_stage   <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            light       <= 3'b000;
          end else if (cur_done && (cur_stage != LAST_STAGE)) begin
            cur_stage   <= next_stage;
            stage_start <= next_start;
            timer       <= '0;
          end else if (cur_done) begin
            // Final stage finished; starts stay as they were for the loops.
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            light <= 3'b010;
          end else if (TIMEOUT_EN && (timer == TIMER_LIMIT)) begin
            state       <= S_ERROR;
            error       <= 1'b1;
            busy        <= 1'b0;
            error_stage <= cur_stage;
            stage_start <= '0;
            light       <= 3'b100;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 24'd1;
          end
        end

        S_DONE, S_ERROR: begin
          if (clear) begin
            state       <= S_IDLE;
            timer       <= '0;
            stage_start <= '0;
            cur_stage   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            error_stage <= '0;
            light       <= 3'b000;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_sequencer
//  Description : Scoreboard bench for stage_sequencer. Two instances share
//                stimulus: A (N=3, hold starts, 8-cycle watchdog) and
//                B (N=3, one-hot starts, no watchdog). A transaction-level
//                reference model predicts each cycle's outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;

  logic       clk;
  logic       rst_n;
  logic       go, abort, clear;
  logic [2:0] stage_done;

  logic [2:0] ss_a, ss_b;
  logic [1:0] cur_a, cur_b, es_a, es_b;
  logic       busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [2:0] light_a, light_b;

  stage_sequencer #(.NUM_STAGES(3), .HOLD_STARTS(1'b1), .TIMEOUT_CYCLES(8)) dut_a (
    .clok(clk), .rst(rst_n), .go(go), .abort(abort), .clear(clear),
    .stage_done(stage_done), .stage_start(ss_a), .cur_stage(cur_a),
    .busy(busy_a), .done(done_a), .error(err_a), .error_stage(es_a),
    .light(light_a)
  );

  stage_sequencer #(.NUM_STAGES(3), .HOLD_STARTS(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clok(clk), .rst(rst_n), .go(go), .abort(abort), .clear(clear),
    .stage_done(stage_done), .stage_start(ss_b), .cur_stage(cur_b),
    .busy(busy_b), .done(done_b), .error(err_b), .error_stage(es_b),
    .light(light_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 waiting, 2 done, 3 error;
  // cnt = number of stages launched so far in this sequence.
  typedef struct {
    int st;
    int cnt;
    int timer;
    int es;
  } ms_t;

  typedef struct packed {
    logic [2:0] ss;
    logic [1:0] cur;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] es;
    logic [2:0] light;
  } exp_t;

  ms_t  sa, sb;
  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic ms_t step(ms_t s, bit rn, bit g, bit ab, bit cl, logic [2:0] dn, int tmo);
    ms_t n = s;
    if (!rn) begin
      n.st = 0; n.cnt = 0; n.timer = 0; n.es = 0;
      return n;
    end
    case (s.st)
      0: if (g) begin n.st = 1; n.cnt = 1; n.timer = 0; end
      1: begin
        if (ab) begin
          n.st = 0; n.cnt = 0;
        end else if (dn[s.cnt-1]) begin
          if (s.cnt < 3) begin n.cnt = s.cnt + 1; n.timer = 0; end
          else n.st = 2;
        end else if (tmo != 0 && s.timer == tmo - 1) begin
          n.st = 3; n.es = s.cnt - 1;
        end else if (s.timer < 24'hFF_FFFF) begin
          n.timer = s.timer + 1;
        end
      end
      default: if (cl) begin n.st = 0; n.cnt = 0; n.es = 0; end
    endcase
    return n;
  endfunction

  function automatic exp_t exp_of(ms_t s, bit hold);
    exp_t e = '0;
    if (s.st == 1 || s.st == 2)
      e.ss = hold ? 3'((1 << s.cnt) - 1) : 3'(1 << (s.cnt - 1));
    e.cur   = 2'((s.cnt == 0) ? 0 : s.cnt - 1);
    e.busy  = (s.st == 1);
    e.done  = (s.st == 2);
    e.err   = (s.st == 3);
    e.es    = (s.st == 3) ? 2'(s.es) : 2'd0;
    e.light = {e.err, e.done, e.busy};
    return e;
  endfunction

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic cmp(string tag, exp_t act, exp_t e);
    chk({tag, ".stage_start"}, int'(act.ss), int'(e.ss));
    chk({tag, ".cur_stage"},   int'(act.cur), int'(e.cur));
    chk({tag, ".busy"},        int'(act.busy), int'(e.busy));
    chk({tag, ".done"},        int'(act.done), int'(e.done));
    chk({tag, ".error"},       int'(act.err), int'(e.err));
    chk({tag, ".error_stage"}, int'(act.es), int'(e.es));
    chk({tag, ".light"},       int'(act.light), int'(e.light));
  endtask

  // Monitor: pops predicted responses and compares against the DUT away from the edge.
  always @(negedge clk) begin
    exp_t e, act;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      act = '{ss: ss_a, cur: cur_a, busy: busy_a, done: done_a, err: err_a, es: es_a, light: light_a};
      cmp("A", act, e);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      act = '{ss: ss_b, cur: cur_b, busy: busy_b, done: done_b, err: err_b, es: es_b, light: light_b};
      cmp("B", act, e);
    end
  end

  // One clock: advance the model on the inputs sampled at this edge, queue predictions.
  task automatic cycle();
    @(posedge clk);
    #1;
    sa = step(sa, rst_n, go, abort, clear, stage_done, 8);
    sb = step(sb, rst_n, go, abort, clear, stage_done, 0);
    qa.push_back(exp_of(sa, 1'b1));
    qb.push_back(exp_of(sb, 1'b0));
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic to_idle();
    go = 0; stage_done = 3'b000; clear = 0;
    abort = 1; cycle();
    abort = 0; clear = 1; cycle();
    clear = 0; cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    sa = '{0, 0, 0, 0};
    sb = '{0, 0, 0, 0};
    rst_n = 0; go = 0; abort = 0; clear = 0; stage_done = 3'b000;
    cycles(3);
    rst_n = 1;
    cycles(2);

    // Nominal sequence: dones 5 cycles apart.
    go = 1; cycle(); go = 0;
    cycles(4); stage_done = 3'b001; cycle(); stage_done = 3'b000;
    cycles(4); stage_done = 3'b010; cycle(); stage_done = 3'b000;
    cycles(4); stage_done = 3'b100; cycle(); stage_done = 3'b000;
    go = 1; cycles(3); go = 0;
    clear = 1; cycle(); clear = 0; cycle();

    // Stage 1 never completes: watchdog on A, B keeps waiting.
    go = 1; cycle(); go = 0;
    stage_done = 3'b001; cycle(); stage_done = 3'b000;
    cycles(11);
    to_idle();

    // Stage 0 done coincides with watchdog expiry.
    go = 1; cycle(); go = 0;
    cycles(7);
    stage_done = 3'b001; cycle(); stage_done = 3'b000;
    cycles(3);
    to_idle();

    // Stage 2 done stuck high.
    stage_done = 3'b100;
    go = 1; cycle(); go = 0;
    stage_done = 3'b101; cycle();
    stage_done = 3'b110; cycle();
    stage_done = 3'b100; cycles(3);
    to_idle();

    // Abort during stage 1, then a fresh start.
    go = 1; cycle(); go = 0;
    stage_done = 3'b001; cycle(); stage_done = 3'b000;
    cycle();
    abort = 1; cycle(); abort = 0; cycle();
    go = 1; cycle(); go = 0;
    cycles(2);
    to_idle();

    // Asynchronous reset while waiting on stage 1.
    go = 1; cycle(); go = 0;
    stage_done = 3'b001; cycle(); stage_done = 3'b000;
    cycles(2);
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    chk("async.A.stage_start", int'(ss_a), 0);
    chk("async.A.busy", int'(busy_a), 0);
    chk("async.A.cur_stage", int'(cur_a), 0);
    chk("async.A.light", int'(light_a), 0);
    chk("async.B.stage_start", int'(ss_b), 0);
    chk("async.B.busy", int'(busy_b), 0);
    cycle();
    rst_n = 1;
    cycle();
    go = 1; cycle(); go = 0;
    cycles(3);
    to_idle();

    // Randomised traffic with varying done density.
    for (int ep = 0; ep < 40; ep++) begin
      int dens;
      dens = $urandom_range(0, 3);
      for (int c = 0; c < 40; c++) begin
        go    = ($urandom_range(0, 3) == 0);
        abort = ($urandom_range(0, 29) == 0);
        clear = ($urandom_range(0, 5) == 0);
        for (int b = 0; b < 3; b++)
          stage_done[b] = (dens == 0) ? 1'b0 :
                          (dens == 1) ? ($urandom_range(0, 11) == 0) :
                          (dens == 2) ? ($urandom_range(0, 2) == 0) :
                                        ($urandom_range(0, 1) == 0);
        cycle();
      end
    end
    to_idle();

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Parametrised N-stage start/done sequencer; it generalises the fixed two-loop handler. It launches NUM_STAGES datapath loops (e.g. init, shuffle, decrypt) strictly in order, each with a start/done handshake. It adds a per-stage watchdog timeout, abort, explicit clear/restart, a selectable start-hold mode and an error-stage report. It sits at top level between the control/key-search logic and the loop datapaths, and drives the status LEDs.

Parameters:
NUM_STAGES, 3, number of sequenced stages (2..16).
HOLD_STARTS, 1, 1 = stage_start bits stay high cumulatively once issued; 0 = only the current stage's start is high.
TIMEOUT_CYCLES, 0, maximum WAIT cycles per stage; 0 disables the watchdog. Range 0..2^24-1.
IDX_W, $clog2(NUM_STAGES), width of stage index outputs (derived; minimum 1).

Ports:
clok  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-low reset.
go  in  1  start a sequence; sampled only in IDLE.
abort  in  1  kill the running sequence; sampled in WAIT.
clear  in  1  return from DONE/ERROR to IDLE.
stage_done  in  NUM_STAGES  per-stage done level from each loop.
stage_start  out  NUM_STAGES  per-stage start level to each loop.
cur_stage  out  IDX_W  index of the stage currently waited on.
busy  out  1  high in WAIT.
done  out  1  high in DONE.
error  out  1  high in ERROR.
error_stage  out  IDX_W  stage that timed out; valid while error=1.
light  out  3  LED status: {error, done, busy}.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous, any state):
  - state=IDLE.
  - stage_start=0, cur_stage=0, busy=0, done=0, error=0, error_stage=0, timer=0.
  - light=3'b000.
- States: IDLE, WAIT, DONE, ERROR.
- IDLE: on go=1, the next edge sets:
  - state=WAIT, cur_stage=0.
  - stage_start=1 on bit 0 only, timer=0, busy=1.
  - go=0: no change.
- WAIT, evaluated each edge in priority order:
  1. abort=1 -> IDLE. stage_start=0, busy=0, cur_stage=0. Abort does not raise error.
  2. stage_done[cur_stage]=1 and cur_stage<NUM_STAGES-1:
     - cur_stage+1; timer=0.
     - stage_start[cur_stage+1]=1.
     - If HOLD_STARTS=0, also clear stage_start[cur_stage]; otherwise lower bits stay 1.
  3. stage_done[cur_stage]=1 and cur_stage=NUM_STAGES-1 -> DONE. busy=0, done=1, stage_start unchanged.
  4. TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 -> ERROR. error=1, busy=0, error_stage=cur_stage, stage_start=0.
  5. Otherwise timer+1, saturating at 2^24-1.
- stage_done bits other than cur_stage are ignored, including early or stuck-high done on future stages.
  - A stuck-high done on the next stage causes it to advance one cycle after its start is issued. Minimum one cycle per stage.
- Done and timeout in the same cycle: done wins (rule 3/2 over 4).
- Stage latency: start is issued on the edge after the previous done is sampled; one idle cycle between stages at most.
- DONE: holds done=1 and stage_start. clear=1 -> IDLE (outputs as reset). go is ignored.
- ERROR: holds error=1 and error_stage. clear=1 -> IDLE (outputs as reset). go is ignored.
- clear is ignored in IDLE and WAIT.
- abort is ignored outside WAIT.
- light={error,done,busy}, registered in the same cycle as the flags.
- Timer is 24 bits; unused when TIMEOUT_CYCLES=0 (may be optimised away).

Test Plan:
1. Nominal, N=3, HOLD=1: go pulse; done0 at +5, done1 at +10, done2 at +15.
   -> stage_start 001 -> 011 -> 111; done=1, light=010 one cycle after done2; cur_stage ends at 2.
2. HOLD=0, N=3, same stimulus -> stage_start 001 -> 010 -> 100; DONE reached with stage_start=100.
3. Timeout, TIMEOUT_CYCLES=8: stage 1 never done.
   -> error=1, error_stage=1, stage_start=000, light=100 exactly 8 WAIT cycles after stage_start[1] rose. clear -> IDLE, all outputs 0.
4. Simultaneous events:
   - stage_done[0] and timeout expiry in the same cycle -> advances to stage 1, no error.
   - stage_done[2] high from reset -> stage 2 completes one cycle after its start.
5. Abort in stage 1 -> IDLE next edge, stage_start=000, error=0. A new go restarts at stage 0.
6. Reset mid-operation: assert rst=0 between edges while in WAIT stage 1.
   -> outputs 0 immediately (asynchronous); after release, go starts a clean sequence from stage 0.
